// File: rtl/sfixed_div_pkg.sv
// Shared types and constants for the sequential signed fixed-point divider.
package sfixed_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  localparam int SAT_W = 128;

  function automatic int calc_iters(input int width, input int fract_width);
    return width + fract_width;
  endfunction

  // Largest positive two's-complement value of the given width, zero-extended.
  function automatic logic [SAT_W-1:0] sat_max(input int width);
    return (SAT_W'(1) << (width - 1)) - SAT_W'(1);
  endfunction

  // Most negative value of the given width (also its magnitude), zero-extended.
  function automatic logic [SAT_W-1:0] sat_min(input int width);
    return SAT_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/sfixed_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module sfixed_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] rem_in,
  input  logic           bit_in,
  input  logic [WIDTH:0] divisor,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  logic [WIDTH+1:0] shifted;

  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? (WIDTH+1)'(shifted - {1'b0, divisor}) : (WIDTH+1)'(shifted);
  end

endmodule

// File: rtl/sfixed_p_std_div_pipe.sv
// Sequential signed Q(INT.FRACT) divider, one quotient bit per cycle, go/done handshake.
// Optional quotient saturation is enabled by defining SFIXED_DIV_SATURATE_EN.
module sfixed_p_std_div_pipe
  import sfixed_div_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done,
  output logic             overflow
);

  localparam int N  = calc_iters(WIDTH, FRACT_WIDTH);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]    LAST  = CW'(N - 1);
  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] Q_MIN = WIDTH'(sat_min(WIDTH));

  if (INT_WIDTH + FRACT_WIDTH != WIDTH) begin : g_bad_cfg
    $error("INT_WIDTH + FRACT_WIDTH must equal WIDTH");
  end

  state_t state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [N-1:0]     work_reg;   // dividend shifts out the top, quotient shifts in the bottom
  logic [WIDTH:0]   rem_reg, div_reg, rem_step;
  logic             q_bit, sign_q_reg, sign_r_reg;
  logic [WIDTH-1:0] quot_reg, remd_reg;
  logic             ovf_reg;
  logic [WIDTH:0]   left_mag, right_mag;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic             ovf_fix;
  logic             div_zero;

  assign div_zero  = (right == '0);
  // WIDTH+1 bits keep the magnitude of the most negative operand intact.
  assign left_mag  = left[WIDTH-1]  ? ((WIDTH+1)'(0) - {left[WIDTH-1], left})   : {1'b0, left};
  assign right_mag = right[WIDTH-1] ? ((WIDTH+1)'(0) - {right[WIDTH-1], right}) : {1'b0, right};

  sfixed_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .bit_in  (work_reg[N-1]),
    .divisor (div_reg),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (go) state_next = div_zero ? DONE : CALC;
      CALC:    if (cnt_reg == LAST) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done = (state_reg == DONE);
  end

  always_comb begin
    rem_fix = WIDTH'(sign_r_reg ? ((WIDTH+1)'(0) - rem_reg) : rem_reg);
`ifdef SFIXED_DIV_SATURATE_EN
    if (!sign_q_reg && work_reg > N'(sat_max(WIDTH))) begin
      quot_fix = Q_MAX;
      ovf_fix  = 1'b1;
    end else if (sign_q_reg && work_reg > N'(sat_min(WIDTH))) begin
      quot_fix = Q_MIN;
      ovf_fix  = 1'b1;
    end else begin
      quot_fix = WIDTH'(sign_q_reg ? (N'(0) - work_reg) : work_reg);
      ovf_fix  = 1'b0;
    end
`else
    quot_fix = WIDTH'(sign_q_reg ? (N'(0) - work_reg) : work_reg);
    ovf_fix  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg    <= '0;
      work_reg   <= '0;
      rem_reg    <= '0;
      div_reg    <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      quot_reg   <= '0;
      remd_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (go && div_zero) begin
            quot_reg <= left[WIDTH-1] ? Q_MIN : Q_MAX;
            remd_reg <= left;
            ovf_reg  <= 1'b1;
          end else if (go) begin
            work_reg   <= N'({left_mag, {FRACT_WIDTH{1'b0}}});
            div_reg    <= right_mag;
            sign_q_reg <= left[WIDTH-1] ^ right[WIDTH-1];
            sign_r_reg <= left[WIDTH-1];
            rem_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        CALC: begin
          rem_reg  <= rem_step;
          work_reg <= {work_reg[N-2:0], q_bit};
          cnt_reg  <= cnt_reg + CW'(1);
        end
        FIXUP: begin
          quot_reg <= quot_fix;
          remd_reg <= rem_fix;
          ovf_reg  <= ovf_fix;
        end
        default: ;
      endcase
    end
  end

  assign out_quotient  = quot_reg;
  assign out_remainder = remd_reg;
  assign overflow      = ovf_reg;

endmodule

// File: tb/tb_sfixed_p_std_div_pipe.sv
// Randomized and directed bench for sfixed_p_std_div_pipe against a 64-bit arithmetic model.
module tb_sfixed_p_std_div_pipe;

  localparam int WIDTH = 32;
  localparam int FRACT = 24;
  localparam int N     = WIDTH + FRACT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic [31:0] left = '0;
  logic [31:0] right = '0;
  logic [31:0] out_quotient, out_remainder;
  logic        done, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  sfixed_p_std_div_pipe #(.WIDTH(WIDTH), .INT_WIDTH(8), .FRACT_WIDTH(FRACT)) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .left          (left),
    .right         (right),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .done          (done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // (left * 2^FRACT) / right with truncating signed division; remainder follows the dividend.
  function automatic void model(input logic [31:0] l, input logic [31:0] r,
                                output logic [31:0] q, output logic [31:0] rem, output logic ovf);
    longint num, den, qq, rr;
    if (r == 32'h0) begin
      q   = l[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      rem = l;
      ovf = 1'b1;
    end else begin
      num = longint'($signed(l)) * 64'sd16777216;
      den = longint'($signed(r));
      qq  = num / den;
      rr  = num % den;
      rem = rr[31:0];
`ifdef SFIXED_DIV_SATURATE_EN
      if (qq > 64'sd2147483647) begin
        q = 32'h7FFF_FFFF; ovf = 1'b1;
      end else if (qq < -64'sd2147483648) begin
        q = 32'h8000_0000; ovf = 1'b1;
      end else begin
        q = qq[31:0]; ovf = 1'b0;
      end
`else
      q   = qq[31:0];
      ovf = 1'b0;
`endif
    end
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit poke_go);
    logic [31:0] eq, er;
    logic        eo;
    int          cyc;
    bit          found;
    model(a, b, eq, er, eo);
    @(negedge clk);
    left = a; right = b; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    found = 1'b0;
    cyc   = 0;
    for (int i = 1; i <= 200 && !found; i++) begin
      @(negedge clk);
      if (poke_go && i == 10) go = 1'b1;
      if (poke_go && i == 11) go = 1'b0;
      if (done) begin
        found = 1'b1;
        cyc   = i;
      end
    end
    check_val("latency", cyc, (b == 32'h0) ? 1 : N + 2);
    check_val("quotient", out_quotient, eq);
    check_val("remainder", out_remainder, er);
    check_val("overflow", overflow, eo);
    $display("[TB] %h / %h -> q=%h r=%h ovf=%b done@%0d", a, b, out_quotient, out_remainder, overflow, cyc);
    @(negedge clk);
    check_val("done_width", done, 1'b0);
    check_val("hold_q", out_quotient, eq);
  endtask

  function automatic logic [31:0] pick(input bit allow_zero);
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h0000_0001;
      3: v = $urandom() >> $urandom_range(1, 31);
      4: v = 32'h0 - ($urandom() >> $urandom_range(1, 31));
      5: v = allow_zero ? 32'h0 : 32'h0100_0000;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_q", out_quotient, 32'h0);
    check_val("rst_r", out_remainder, 32'h0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_ovf", overflow, 1'b0);
    reset = 1'b1;

    run_div(32'h0600_0000, 32'h0200_0000, 1'b0);
    check_val("6/2_q", out_quotient, 32'h0300_0000);
    check_val("6/2_r", out_remainder, 32'h0);
    run_div(32'hF880_0000, 32'h0200_0000, 1'b0);
    check_val("-7.5/2_q", out_quotient, 32'hFC40_0000);
    run_div(32'h0100_0000, 32'h0300_0000, 1'b0);
    check_val("1/3_q", out_quotient, 32'h0055_5555);
    check_val("1/3_r", out_remainder, 32'h0100_0000);
    run_div(32'h6400_0000, 32'h0002_0000, 1'b0);
`ifdef SFIXED_DIV_SATURATE_EN
    check_val("big_q", out_quotient, 32'h7FFF_FFFF);
    check_val("big_ovf", overflow, 1'b1);
`else
    check_val("big_q", out_quotient, 32'h0);
    check_val("big_ovf", overflow, 1'b0);
`endif
    run_div(32'h0500_0000, 32'h0, 1'b0);
    check_val("5/0_q", out_quotient, 32'h7FFF_FFFF);
    check_val("5/0_ovf", overflow, 1'b1);
    run_div(32'hFB00_0000, 32'h0, 1'b0);
    check_val("-5/0_q", out_quotient, 32'h8000_0000);

    // Abort in CALC cycle 20 while the outputs still hold the previous nonzero result.
    @(negedge clk);
    left = 32'h0600_0000; right = 32'h0200_0000; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("abort_q", out_quotient, 32'h0);
    check_val("abort_r", out_remainder, 32'h0);
    check_val("abort_ovf", overflow, 1'b0);
    check_val("abort_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run_div(32'h0600_0000, 32'h0200_0000, 1'b1);
    check_val("after_abort_q", out_quotient, 32'h0300_0000);

    for (int k = 0; k < 40; k++) begin
      run_div(pick(1'b1), pick(1'b1), k[2]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sfixed_p_std_div_pipe.md
# sfixed_p_std_div_pipe

Multi-cycle signed fixed-point divider for the fixed-point primitive library. It computes `(left << FRACT_WIDTH) / right` by restoring division, one quotient bit per cycle, and corrects the sign at the end. It sits alongside the combinational signed add/sub/mult primitives: it consumes their WIDTH-bit two's-complement Q(INT.FRACT) results and feeds the same format downstream. It is the sequential replacement for the combinational fixed-point divide and uses the go/done handshake.

## Interface
- WIDTH, 32, total operand/result width
- INT_WIDTH, 8, integer bits including sign
- FRACT_WIDTH, 24, fraction bits; INT_WIDTH+FRACT_WIDTH must equal WIDTH
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state clears immediately on assertion
- go  in  1  start request, sampled only in IDLE
- left  in  WIDTH  signed dividend, Q(INT.FRACT)
- right  in  WIDTH  signed divisor, Q(INT.FRACT)
- out_quotient  out  WIDTH  signed quotient, Q(INT.FRACT), truncated toward zero
- out_remainder  out  WIDTH  signed remainder of the scaled division; takes the dividend's sign
- done  out  1  one-cycle completion pulse
- overflow  out  1  quotient exceeded range (Configuration); held with the outputs

## Operation
- N = WIDTH+FRACT_WIDTH iterations; counter width $clog2(N+1).
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, go=1, right!=0:
  - latch |left|<<FRACT_WIDTH as the N-bit dividend magnitude and |right|
  - latch sign_q = left[MSB]^right[MSB] and sign_r = left[MSB]
  - clear the partial remainder and counter; go to CALC
- IDLE, go=1, right==0: go to DONE directly.
  - out_quotient = 0x7FF..F if left>=0, else 0x800..0
  - out_remainder = left
  - overflow = 1
- CALC: shift the next dividend bit into the partial remainder (width WIDTH+1).
  - If the remainder is >= |right|, subtract and shift in quotient bit 1; otherwise shift in 0.
  - After iteration N-1, go to FIXUP.
- FIXUP: negate the magnitude quotient if sign_q, and the remainder if sign_r; apply the overflow rule; register the outputs; go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Outputs hold their value until the next FIXUP or divide-by-zero capture.
- Magnitude of the most negative operand (0x800..0) is formed in WIDTH+1 bits, so it is never lost.
- go while in CALC, FIXUP or DONE is ignored. The caller deasserts go in the cycle it observes done; go still high in IDLE starts a new operation.
- Asynchronous reset mid-operation aborts it: state IDLE, all outputs 0, no done pulse.

## Timing
- Reset values: out_quotient=0, out_remainder=0, done=0, overflow=0, state IDLE.
- go accepted at cycle 0 (right!=0): CALC occupies cycles 1..N, FIXUP is cycle N+1, done=1 in cycle N+2.
  - Default parameters: N=56, done in cycle 58.
- Divide by zero: done=1 in cycle 1.
- Outputs are valid and stable from the done cycle onward.
- Back-to-back operations: the minimum spacing between go acceptances is N+3 cycles.

## Configuration
- SFIXED_DIV_SATURATE_EN defined: a magnitude quotient above 2^(WIDTH-1)-1 (positive result) or above 2^(WIDTH-1) (negative result) is clamped.
  - Result becomes 0x7FF..F or 0x800..0 respectively, with overflow=1.
- SFIXED_DIV_SATURATE_EN undefined: the quotient is the low WIDTH bits of the signed result (wrap).
  - overflow=1 only for divide by zero.
- The divide-by-zero behaviour is identical in both builds.

## Structure
- Package sfixed_div_pkg holds:
  - state typedef enum {IDLE, CALC, FIXUP, DONE}
  - localparam function for N
  - saturation constant functions for the max-positive and min-negative values of a width
- Sub-module sfixed_div_step: combinational, one restoring step. Input is the partial remainder, dividend bit and divisor; outputs are the next remainder and the quotient bit. Instantiated once.

## Test plan
All scenarios use default parameters (1.0 = 0x0100_0000).
- 6.0/2.0 (0x0600_0000, 0x0200_0000) -> out_quotient 0x0300_0000, out_remainder 0, done exactly in cycle 58, one cycle wide.
- -7.5/2.0 (0xF880_0000, 0x0200_0000) -> out_quotient 0xFC40_0000 (-3.75).
- 1.0/3.0 (0x0100_0000, 0x0300_0000) -> out_quotient 0x0055_5555, out_remainder 0x0100_0000.
- 5.0/0 -> out_quotient 0x7FFF_FFFF, overflow=1, done in cycle 1. -5.0/0 -> 0x8000_0000.
- 100.0/0.0078125 (0x6400_0000, 0x0002_0000):
  - with SFIXED_DIV_SATURATE_EN -> out_quotient 0x7FFF_FFFF, overflow=1
  - without it -> out_quotient 0x0000_0000, overflow=0
- Reset asserted in CALC cycle 20 -> outputs 0 and done 0 immediately. A go after release completes 6.0/2.0 correctly in 58 cycles. A go pulse during CALC is ignored.
